// File: rtl/seg_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder_pkg
// Description : Seven-segment glyph table (gfedcba, active-high) and scan
//               decoder FSM state encodings, shared by encoder and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_decoder_pkg;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_A     = 7'h77;
   localparam logic [6:0] GLYPH_B     = 7'h7C;
   localparam logic [6:0] GLYPH_C     = 7'h39;
   localparam logic [6:0] GLYPH_D     = 7'h5E;
   localparam logic [6:0] GLYPH_E     = 7'h79;
   localparam logic [6:0] GLYPH_F     = 7'h71;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   typedef enum logic [1:0] {
      ST_WAIT_SEL = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_HELD     = 2'd2
   } scan_state_t;

   function automatic logic [6:0] nibble_to_glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = GLYPH_0;
         4'h1:    g = GLYPH_1;
         4'h2:    g = GLYPH_2;
         4'h3:    g = GLYPH_3;
         4'h4:    g = GLYPH_4;
         4'h5:    g = GLYPH_5;
         4'h6:    g = GLYPH_6;
         4'h7:    g = GLYPH_7;
         4'h8:    g = GLYPH_8;
         4'h9:    g = GLYPH_9;
         4'hA:    g = GLYPH_A;
         4'hB:    g = GLYPH_B;
         4'hC:    g = GLYPH_C;
         4'hD:    g = GLYPH_D;
         4'hE:    g = GLYPH_E;
         default: g = GLYPH_F;
      endcase
      return g;
   endfunction

endpackage : seg_scan_decoder_pkg
`default_nettype wire

// File: rtl/seg_glyph_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_glyph_decode
// Description : Combinational glyph-to-nibble decoder (active-high gfedcba).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_decode
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] i_glyph,
   output logic       o_valid,
   output logic       o_blank,
   output logic [3:0] o_nibble
);

   always_comb begin : p_decode
      o_valid  = 1'b0;
      o_blank  = 1'b0;
      o_nibble = 4'h0;
      if (i_glyph == GLYPH_BLANK) begin
         o_valid = 1'b1;
         o_blank = 1'b1;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (i_glyph == nibble_to_glyph(4'(i))) begin
               o_valid  = 1'b1;
               o_nibble = 4'(i);
            end
         end
      end
   end

endmodule : seg_glyph_decode
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Samples a scanned 4-digit seven-segment bus and rebuilds the
//               displayed 16-bit value, flagging bad glyphs/selects/timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1,
   parameter int SETTLE_CYCLES  = 4,
   parameter int FRAME_TIMEOUT  = 2000000
) (
   input  logic        clk_50MHz,
   input  logic        reset,
   input  logic [7:0]  seg,
   input  logic [3:0]  digit,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic [3:0]  blank,
   output logic        value_valid,
   output logic        glyph_err,
   output logic        sel_err,
   output logic        timeout
);

   localparam int                 c_cnt_w       = $clog2(SETTLE_CYCLES + 1);
   localparam int                 c_to_w        = $clog2(FRAME_TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_to_w-1:0]  c_to_last     = c_to_w'(FRAME_TIMEOUT - 1);

   logic [7:0]         r_s, r_s_prev;
   logic [3:0]         r_d, r_d_prev;
   scan_state_t        r_state, w_state_nxt, w_go_state;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_go_cnt;
   logic               w_sample, w_go_sample, w_sel_err, w_go_sel_err;
   logic               w_d_onehot, w_d_multi, w_changed, w_d_changed;
   logic [1:0]         w_dig_idx;
   logic               w_glyph_valid, w_glyph_blank;
   logic [3:0]         w_glyph_nibble, w_cap_set;
   logic [15:0]        r_stg_value, r_value;
   logic [3:0]         r_stg_dp, r_stg_blank, r_dp, r_blank, r_captured;
   logic [c_to_w-1:0]  r_to_cnt;
   logic               r_value_valid, r_glyph_err, r_sel_err, r_timeout;

   // Pins are normalised while being registered, so a reset copy reads as
   // "nothing lit, nothing selected" whatever the pin polarity.
   always_ff @(posedge clk_50MHz) begin : p_in_reg
      if (reset) begin
         r_s      <= 8'h00;
         r_d      <= 4'h0;
         r_s_prev <= 8'h00;
         r_d_prev <= 4'h0;
      end else begin
         r_s      <= (SEG_ACTIVE_LOW != 0) ? ~seg   : seg;
         r_d      <= (DIG_ACTIVE_LOW != 0) ? ~digit : digit;
         r_s_prev <= r_s;
         r_d_prev <= r_d;
      end
   end

   assign w_d_onehot  = (r_d != 4'h0) && ((r_d & (r_d - 4'h1)) == 4'h0);
   assign w_d_multi   = (r_d != 4'h0) && !w_d_onehot;
   assign w_d_changed = (r_d != r_d_prev);
   assign w_changed   = w_d_changed || (r_s != r_s_prev);

   always_comb begin : p_dig_idx
      w_dig_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (r_d[i]) w_dig_idx = 2'(i);
      end
   end

   seg_glyph_decode u_glyph (
      .i_glyph  (r_s[6:0]),
      .o_valid  (w_glyph_valid),
      .o_blank  (w_glyph_blank),
      .o_nibble (w_glyph_nibble)
   );

   // Reaction to a fresh select pattern, shared by WAIT_SEL and any change
   // seen while settling or holding.  Only a new multi-hot edge reports.
   always_comb begin : p_go
      w_go_state   = ST_WAIT_SEL;
      w_go_cnt     = '0;
      w_go_sample  = 1'b0;
      w_go_sel_err = 1'b0;
      if (w_d_onehot) begin
         if (SETTLE_CYCLES <= 1) begin
            w_go_state  = ST_HELD;
            w_go_sample = 1'b1;
         end else begin
            w_go_state = ST_SETTLE;
            w_go_cnt   = c_cnt_one;
         end
      end else if (w_d_multi) begin
         w_go_sel_err = w_d_changed;
      end
   end

   always_comb begin : p_next
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sample    = 1'b0;
      w_sel_err   = 1'b0;
      case (r_state)
         ST_SETTLE: begin
            if (!w_changed) begin
               if (r_cnt == c_settle_last) begin
                  w_state_nxt = ST_HELD;
                  w_sample    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end else begin
               w_state_nxt = w_go_state;
               w_cnt_nxt   = w_go_cnt;
               w_sample    = w_go_sample;
               w_sel_err   = w_go_sel_err;
            end
         end
         ST_HELD: begin
            if (w_changed) begin
               w_state_nxt = w_go_state;
               w_cnt_nxt   = w_go_cnt;
               w_sample    = w_go_sample;
               w_sel_err   = w_go_sel_err;
            end
         end
         default: begin
            w_state_nxt = w_go_state;
            w_cnt_nxt   = w_go_cnt;
            w_sample    = w_go_sample;
            w_sel_err   = w_go_sel_err;
         end
      endcase
   end

   always_ff @(posedge clk_50MHz) begin : p_state
      if (reset) begin
         r_state <= ST_WAIT_SEL;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign w_cap_set = (w_sample && w_glyph_valid) ? r_d : 4'h0;

   // A sample on the frame-complete clock lands in the freshly cleared mask,
   // while the published frame uses staging as it stood before this edge.
   always_ff @(posedge clk_50MHz) begin : p_frame
      if (reset) begin
         r_stg_value   <= 16'h0000;
         r_stg_dp      <= 4'h0;
         r_stg_blank   <= 4'h0;
         r_captured    <= 4'h0;
         r_value       <= 16'h0000;
         r_dp          <= 4'h0;
         r_blank       <= 4'hF;
         r_value_valid <= 1'b0;
         r_glyph_err   <= 1'b0;
         r_sel_err     <= 1'b0;
         r_timeout     <= 1'b0;
         r_to_cnt      <= '0;
      end else begin
         r_glyph_err   <= w_sample && !w_glyph_valid;
         r_sel_err     <= w_sel_err;
         r_value_valid <= 1'b0;
         r_timeout     <= 1'b0;
         if (w_sample && w_glyph_valid) begin
            r_stg_value[{w_dig_idx, 2'b00} +: 4] <= w_glyph_nibble;
            r_stg_dp[w_dig_idx]                  <= r_s[7];
            r_stg_blank[w_dig_idx]               <= w_glyph_blank;
         end
         if (r_captured == 4'hF) begin
            r_value       <= r_stg_value;
            r_dp          <= r_stg_dp;
            r_blank       <= r_stg_blank;
            r_value_valid <= 1'b1;
            r_captured    <= w_cap_set;
            r_to_cnt      <= '0;
         end else if (r_captured != 4'h0) begin
            if (r_to_cnt == c_to_last) begin
               r_timeout  <= 1'b1;
               r_captured <= 4'h0;
               r_to_cnt   <= '0;
            end else begin
               r_to_cnt   <= r_to_cnt + 1'b1;
               r_captured <= r_captured | w_cap_set;
            end
         end else begin
            r_to_cnt   <= '0;
            r_captured <= w_cap_set;
         end
      end
   end

   assign value       = r_value;
   assign dp          = r_dp;
   assign blank       = r_blank;
   assign value_valid = r_value_valid;
   assign glyph_err   = r_glyph_err;
   assign sel_err     = r_sel_err;
   assign timeout     = r_timeout;

endmodule : seg_scan_decoder
`default_nettype wire
